// File: rtl/event_blinker_pkg.sv
// Shared constants and types for the board-level event/LED helpers.
// Holds the blinker state encoding and the ms-to-cycles helper used by the debouncer too.
package event_blinker_pkg;

  localparam int unsigned CLK_HZ = 10_000_000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ON   = 2'd1,
    ST_OFF  = 2'd2
  } blink_state_e;

  function automatic int unsigned ms_to_cycles(input int unsigned ms);
    return (CLK_HZ / 1000) * ms;
  endfunction

  localparam int unsigned DEBOUNCE_CYCLES = ms_to_cycles(20);

endpackage

// File: rtl/event_blinker.sv
// Turns single-cycle event strobes into visible LED blinks (ON then enforced OFF gap).
// Events arriving mid-blink are queued in a saturating counter and replayed back-to-back.
module event_blinker
  import event_blinker_pkg::*;
#(
  parameter int unsigned ON_CYCLES  = ms_to_cycles(200),
  parameter int unsigned OFF_CYCLES = ms_to_cycles(150),
  parameter int unsigned PEND_MAX   = 15
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            evt,
  output logic                            led,
  output logic                            busy,
  output logic [$clog2(PEND_MAX+1)-1:0]   pending,
  output logic                            ovf
);

  localparam int unsigned PEND_W  = $clog2(PEND_MAX + 1);
  localparam int unsigned TMR_MAX = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
  localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);

  localparam logic [TMR_W-1:0]  ON_LOAD  = TMR_W'(ON_CYCLES - 1);
  localparam logic [TMR_W-1:0]  OFF_LOAD = TMR_W'(OFF_CYCLES - 1);
  localparam logic [PEND_W-1:0] PEND_TOP = PEND_W'(PEND_MAX);

  blink_state_e      state_q, state_d;
  logic [TMR_W-1:0]  timer_q, timer_d;
  logic [PEND_W-1:0] pend_q,  pend_d;
  logic              led_q,   led_d;
  logic              busy_q,  busy_d;
  logic              ovf_q,   ovf_d;

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      timer_q <= '0;
      pend_q  <= '0;
      led_q   <= 1'b0;
      busy_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      pend_q  <= pend_d;
      led_q   <= led_d;
      busy_q  <= busy_d;
      ovf_q   <= ovf_d;
    end
  end

  // Next-state, shared timer and pending-queue update.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    pend_d  = pend_q;
    led_d   = led_q;
    ovf_d   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (evt) begin
          state_d = ST_ON;
          timer_d = ON_LOAD;
          led_d   = 1'b1;
        end
      end

      ST_ON: begin
        if (timer_q == '0) begin
          state_d = ST_OFF;
          timer_d = OFF_LOAD;
          led_d   = 1'b0;
        end else begin
          timer_d = timer_q - TMR_W'(1);
        end
        if (evt) begin
          if (pend_q == PEND_TOP) ovf_d  = 1'b1;
          else                    pend_d = pend_q + PEND_W'(1);
        end
      end

      ST_OFF: begin
        if (timer_q == '0) begin
          // Restart: a new event alongside a queued one nets out to no change.
          if ((pend_q != '0) || evt) begin
            state_d = ST_ON;
            timer_d = ON_LOAD;
            led_d   = 1'b1;
            if ((pend_q != '0) && !evt) pend_d = pend_q - PEND_W'(1);
          end else begin
            state_d = ST_IDLE;
            led_d   = 1'b0;
          end
        end else begin
          timer_d = timer_q - TMR_W'(1);
          if (evt) begin
            if (pend_q == PEND_TOP) ovf_d  = 1'b1;
            else                    pend_d = pend_q + PEND_W'(1);
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
        timer_d = '0;
        led_d   = 1'b0;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  assign led     = led_q;
  assign busy    = busy_q;
  assign pending = pend_q;
  assign ovf     = ovf_q;

endmodule

// File: tb/tb_event_blinker.sv
// Self-checking bench for event_blinker with ON=4, OFF=3, PEND_MAX=3.
// Cycle c inputs are driven before edge c+1; expected outputs are those seen in cycle c+1.
module tb_event_blinker;

  typedef struct packed {
    logic       led;
    logic       busy;
    logic [1:0] pend;
    logic       ovf;
  } out_t;

  typedef struct {
    logic rst;
    logic evt;
    out_t exp;
  } vec_t;

  typedef struct {
    out_t  exp;
    string name;
    int    cyc;
  } sb_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       evt = 1'b0;
  logic       led;
  logic       busy;
  logic [1:0] pending;
  logic       ovf;

  int n_cmp = 0;
  int n_err = 0;

  sb_t  sb[$];
  vec_t tbl[$];

  event_blinker #(
    .ON_CYCLES  (4),
    .OFF_CYCLES (3),
    .PEND_MAX   (3)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .evt     (evt),
    .led     (led),
    .busy    (busy),
    .pending (pending),
    .ovf     (ovf)
  );

  always #5 clk = ~clk;

  function automatic out_t mk(input logic l, input logic b, input int p, input logic o);
    out_t r;
    r.led  = l;
    r.busy = b;
    r.pend = 2'(p);
    r.ovf  = o;
    return r;
  endfunction

  function automatic logic on_at(input int t, input int s);
    return (t >= s) && (t < s + 4);
  endfunction

  task automatic drive(input logic r, input logic e, input out_t x, input string nm, input int c);
    sb_t item;
    @(negedge clk);
    rst = r;
    evt = e;
    item.exp  = x;
    item.name = nm;
    item.cyc  = c + 1;
    sb.push_back(item);
  endtask

  task automatic add(input logic r, input logic e, input logic l, input logic b,
                     input int p, input logic o);
    vec_t v;
    v.rst = r;
    v.evt = e;
    v.exp = mk(l, b, p, o);
    tbl.push_back(v);
  endtask

  // Scoreboard checker: one expected record retires per clock.
  always begin
    sb_t  item;
    out_t act;
    @(posedge clk);
    #1;
    if (sb.size() != 0) begin
      item = sb.pop_front();
      act  = mk(led, busy, int'(pending), ovf);
      n_cmp++;
      if (act !== item.exp) begin
        n_err++;
        $display("FAIL %s cyc %0d: got led=%b busy=%b pend=%0d ovf=%b, want led=%b busy=%b pend=%0d ovf=%b",
                 item.name, item.cyc, act.led, act.busy, act.pend, act.ovf,
                 item.exp.led, item.exp.busy, item.exp.pend, item.exp.ovf);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    int p;
    logic e;
    logic r;

    // Table: single blink, idle, then restart on the last OFF cycle.
    add(1, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0);
    add(0, 1, 1, 1, 0, 0);
    for (int i = 0; i < 3; i++) add(0, 0, 1, 1, 0, 0);
    for (int i = 0; i < 3; i++) add(0, 0, 0, 1, 0, 0);
    add(0, 0, 0, 0, 0, 0);
    add(0, 1, 1, 1, 0, 0);
    for (int i = 0; i < 3; i++) add(0, 0, 1, 1, 0, 0);
    for (int i = 0; i < 3; i++) add(0, 0, 0, 1, 0, 0);
    add(0, 1, 1, 1, 0, 0);
    for (int i = 0; i < 3; i++) add(0, 0, 1, 1, 0, 0);
    for (int i = 0; i < 3; i++) add(0, 0, 0, 1, 0, 0);
    add(0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < tbl.size(); i++) drive(tbl[i].rst, tbl[i].evt, tbl[i].exp, "table", i);

    // Back-to-back: events at 10,11,12.
    drive(1, 0, mk(0, 0, 0, 0), "b2b_reset", 0);
    for (int c = 1; c <= 40; c++) begin
      t = c + 1;
      p = (t < 12) ? 0 : (t == 12) ? 1 : (t < 18) ? 2 : (t < 25) ? 1 : 0;
      drive(0, (c >= 10 && c <= 12),
            mk(on_at(t, 11) | on_at(t, 18) | on_at(t, 25), (t >= 11 && t <= 31), p, 0),
            "b2b", c);
    end

    // Overflow: events 10..14 saturate the queue, one dropped.
    drive(1, 0, mk(0, 0, 0, 0), "ovf_reset", 0);
    for (int c = 1; c <= 45; c++) begin
      t = c + 1;
      p = (t < 12) ? 0 : (t == 12) ? 1 : (t == 13) ? 2 : (t < 18) ? 3 :
          (t < 25) ? 2 : (t < 32) ? 1 : 0;
      drive(0, (c >= 10 && c <= 14),
            mk(on_at(t, 11) | on_at(t, 18) | on_at(t, 25) | on_at(t, 32),
               (t >= 11 && t <= 38), p, (t == 15)),
            "overflow", c);
    end

    // Full queue plus event on the restart cycle: no change, no ovf.
    drive(1, 0, mk(0, 0, 0, 0), "cancel_reset", 0);
    for (int c = 1; c <= 50; c++) begin
      t = c + 1;
      p = (t < 12) ? 0 : (t == 12) ? 1 : (t == 13) ? 2 : (t < 25) ? 3 :
          (t < 32) ? 2 : (t < 39) ? 1 : 0;
      drive(0, ((c >= 10 && c <= 14) || c == 17),
            mk(on_at(t, 11) | on_at(t, 18) | on_at(t, 25) | on_at(t, 32) | on_at(t, 39),
               (t >= 11 && t <= 45), p, (t == 15)),
            "cancel_full", c);
    end

    // Reset mid-blink discards queued events.
    drive(1, 0, mk(0, 0, 0, 0), "rstmid_reset", 0);
    for (int c = 1; c <= 43; c++) begin
      t = c + 1;
      r = (c == 13);
      e = (c >= 10 && c <= 12);
      if (t >= 14) begin
        drive(r, e, mk(0, 0, 0, 0), "rst_mid", c);
      end else begin
        p = (t < 12) ? 0 : (t == 12) ? 1 : 2;
        drive(r, e, mk(on_at(t, 11), (t >= 11), p, 0), "rst_mid", c);
      end
    end

    // Held strobe: two cycles high means two blinks.
    drive(1, 0, mk(0, 0, 0, 0), "held_reset", 0);
    for (int c = 1; c <= 30; c++) begin
      t = c + 1;
      drive(0, (c >= 10 && c <= 11),
            mk(on_at(t, 11) | on_at(t, 18), (t >= 11 && t <= 24), (t >= 12 && t <= 17) ? 1 : 0, 0),
            "held", c);
    end

    @(posedge clk);
    #3;
    if (sb.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain: got %0d unretired records, want 0", sb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/event_blinker.md
Name: event_blinker

Overview:
- Output-side counterpart of the button debouncer: it turns single-clock event strobes into human-visible LED blinks.
- Each accepted strobe produces exactly one blink: ON for ON_CYCLES, then OFF for OFF_CYCLES.
- Strobes arriving while a blink is in progress are queued in a saturating pending counter and replayed back-to-back.
- Sits between press_edge-style event sources and the board LEDs or 7-segment decimal points.

Parameters:
- ON_CYCLES, 2_000_000, LED-on duration per blink in clk cycles (200 ms at 10 MHz); must be >= 1.
- OFF_CYCLES, 1_500_000, enforced dark gap after each blink in clk cycles (150 ms); must be >= 1.
- PEND_MAX, 15, maximum number of queued events; pending width = clog2(PEND_MAX+1).

Ports:
- clk  in  1  system clock (10 MHz on board).
- rst  in  1  synchronous reset, active-high.
- evt  in  1  event strobe; every cycle sampled high counts as one event.
- led  out  1  registered blink output.
- busy  out  1  registered; high whenever state != IDLE.
- pending  out  clog2(PEND_MAX+1)  registered count of queued events not yet started.
- ovf  out  1  registered one-cycle pulse when an event is dropped because the queue is full.

Behaviour:
- Single clock domain; synchronous, active-high reset.
- Reset (sampled on clk edge): state=IDLE, led=0, busy=0, pending=0, ovf=0, timer=0. Applies mid-operation: after the reset edge everything is cleared, queued events are discarded, and no further blinks occur.
- FSM states: IDLE, ON, OFF. A single down-counter timer is shared; width = clog2(max(ON_CYCLES, OFF_CYCLES)+1).
- IDLE:
  - evt=1 -> ON, timer=ON_CYCLES-1, led=1.
  - Latency is 1 cycle: led is high on the cycle after evt is sampled.
  - pending is unchanged.
- ON:
  - led=1 for exactly ON_CYCLES cycles.
  - When timer==0 -> OFF, timer=OFF_CYCLES-1, led=0.
- OFF:
  - led=0 for exactly OFF_CYCLES cycles.
  - When timer==0: if pending>0 or evt=1 -> ON (reload timer, led=1); otherwise -> IDLE.
- Queue update, any state other than IDLE, excluding the OFF-to-ON transition cycle:
  - evt=1 and pending<PEND_MAX -> pending+1.
  - evt=1 and pending==PEND_MAX -> pending unchanged, ovf=1 for one cycle.
- OFF-to-ON transition cycle:
  - pending>0, evt=0 -> pending-1.
  - pending>0, evt=1 -> pending unchanged (decrement and increment cancel); no ovf, even at PEND_MAX.
  - pending==0, evt=1 -> the new event starts directly; pending stays 0.
- No IDLE gap between queued blinks. Blink period is exactly ON_CYCLES+OFF_CYCLES.
- ovf defaults to 0 every cycle; it is never asserted in IDLE.
- busy=1 from the first ON cycle through the last OFF cycle; it falls together with the IDLE entry.
- evt held high for N cycles counts as N events; the block performs no edge detection.
- Every event produces exactly one blink unless it is dropped, and every dropped event yields exactly one ovf pulse.

Decomposition:
- Shared package/include holds:
  - state encoding localparams (IDLE, ON, OFF);
  - CLK_HZ = 10_000_000;
  - an ms-to-cycles constant function, shared with the debouncer's 20 ms constant.
- No sub-module is needed. Timer, queue counter and FSM stay inline in a single always block plus registered outputs; estimated 120-160 lines.

Test Plan (ON_CYCLES=4, OFF_CYCLES=3, PEND_MAX=3):
- Single blink: evt pulse at cycle 10 -> led=1 cycles 11-14, led=0 cycles 15-17 with busy=1, busy=0 from cycle 18, pending=0 throughout.
- Back-to-back events: evt at cycles 10, 11, 12 -> pending goes 1, 2, then 1 at cycle 18, then 0 at cycle 25. Three blinks with rising edges at 11, 18, 25; busy low from 32.
- Overflow: evt high cycles 10-14 (5 events) -> pending saturates at 3 (cycle 14), ovf=1 only on cycle 15. Exactly 4 blinks; no other ovf pulses.
- Seamless restart: single blink from cycle 10, second evt at cycle 17 (last OFF cycle) -> led rises again at cycle 18, busy never drops, pending stays 0.
- Reset mid-blink: evt at cycles 10, 11, 12, rst=1 at cycle 13 -> from cycle 14 led=0, busy=0, pending=0, ovf=0. No further blinks in the following 30 cycles.
- Held strobe: evt high cycles 10-11 -> two blinks, rising edges at 11 and 18, pending peaks at 1.
